// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length, transmit FSM states and the
// symbol-time helper used by both transmit and receive sides.
package uart_pkg;

    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_tx_state_t;

    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud);
        return clock_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset, full and empty flags.
// Depth must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == (PtrW + 1)'(Depth));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with ready/valid byte input. Define
// UART_TRANSMITTER_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       tx_busy
);

    localparam int unsigned SymbolTime = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SymCntW    = (SymbolTime > 1) ? $clog2(SymbolTime) : 1;
    localparam logic [SymCntW-1:0] SymLast = SymCntW'(SymbolTime - 1);
    localparam int unsigned DataBits   = UART_FRAME_BITS - 2;
    localparam logic [2:0] BitLast     = 3'(DataBits - 1);

    uart_tx_state_t     state_q, state_d;
    logic [SymCntW-1:0] sym_cnt_q, sym_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               serial_q, serial_d;
    logic               tx_busy_q, tx_busy_d;

    logic       have_byte;
    logic [7:0] next_byte;
    logic       take_byte;
    logic       buffered;
    logic       sym_wrap;

`ifdef UART_TRANSMITTER_FIFO_EN
    localparam bit ChainFrames = 1'b1;

    logic       fifo_full, fifo_empty, fifo_push;
    logic [7:0] fifo_data;

    assign data_in_ready = !fifo_full && !rst;
    assign fifo_push     = data_in_valid && data_in_ready;
    assign have_byte     = !fifo_empty;
    assign next_byte     = fifo_data;
    assign buffered      = fifo_push || !fifo_empty;

    uart_sync_fifo #(
        .Width(8),
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(data_in),
        .pop      (take_byte),
        .pop_data (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
`else
    localparam bit ChainFrames = 1'b0;

    // Without a FIFO the shifter is the only buffer; depth and pop are irrelevant.
    logic unused_cfg;
    assign unused_cfg = ^{FIFO_DEPTH, take_byte};

    assign data_in_ready = (state_q == StIdle) && !rst;
    assign have_byte     = data_in_valid && data_in_ready;
    assign next_byte     = data_in;
    assign buffered      = 1'b0;
`endif

    assign sym_wrap   = (sym_cnt_q == SymLast);
    assign serial_out = serial_q;
    assign tx_busy    = tx_busy_q;
    assign tx_busy_d  = (state_d != StIdle) || buffered;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sym_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            tx_busy_q <= tx_busy_d;
        end
    end

    // serial_d always carries the level of the symbol that starts on the next edge.
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        take_byte = 1'b0;

        case (state_q)
            StIdle: begin
                serial_d = 1'b1;
                if (have_byte) begin
                    take_byte = 1'b1;
                    shift_d   = next_byte;
                    serial_d  = 1'b0;
                    sym_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (sym_wrap) begin
                    sym_cnt_d = '0;
                    bit_cnt_d = '0;
                    serial_d  = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    state_d   = StData;
                end else begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (sym_wrap) begin
                    sym_cnt_d = '0;
                    if (bit_cnt_q == BitLast) begin
                        serial_d = 1'b1;
                        state_d  = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        serial_d  = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (sym_wrap) begin
                    sym_cnt_d = '0;
                    // With a FIFO the next start bit follows the stop bit directly.
                    if (ChainFrames && have_byte) begin
                        take_byte = 1'b1;
                        shift_d   = next_byte;
                        serial_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = StStart;
                    end else begin
                        serial_d = 1'b1;
                        state_d  = StIdle;
                    end
                end else begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
            end
            default: begin
                serial_d = 1'b1;
                state_d  = StIdle;
            end
        endcase
    end

endmodule
